// File: rtl/ysyx_24100005_core_seq.sv
// ysyx_24100005_core_seq: multi-cycle fetch/wait/exec sequencer with ebreak halt and fetch timeout
// Ports: clk/rst (async active-low); imem_req/imem_addr out, imem_rvalid/imem_rdata in;
// exec_stall in; inst/pc/instret/rf_wen out; sticky halt and fetch_err out.
module ysyx_24100005_core_seq #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        exec_stall,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        rf_wen,
    output logic [31:0] instret,
    output logic        halt,
    output logic        fetch_err
);
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [7:0]  LAST   = 8'(TIMEOUT - 1);
    typedef enum logic [2:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT, S_ERR} state_e;
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, instret_q, instret_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        halt_q, halt_d, err_q, err_d;
    logic        is_ebreak, retire, wr_op, timed_out;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            instret_q <= '0;
            cnt_q     <= '0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
            cnt_q     <= cnt_d;
            halt_q    <= halt_d;
            err_q     <= err_d;
        end
    end
    assign is_ebreak = inst_q == EBREAK;
    assign timed_out = state_q == S_WAIT && !imem_rvalid && cnt_q == LAST;
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = imem_rvalid ? S_EXEC : (timed_out ? S_ERR : S_WAIT);
            S_EXEC:  state_d = exec_stall ? S_EXEC : (is_ebreak ? S_HALT : S_FETCH);
            default: state_d = state_q;
        endcase
    end
    always_comb begin
        retire    = state_q == S_EXEC && !exec_stall && !is_ebreak;
        pc_d      = retire ? pc_q + 32'd4 : pc_q;
        instret_d = retire ? instret_q + 32'd1 : instret_q;
        inst_d    = (state_q == S_WAIT && imem_rvalid) ? imem_rdata : inst_q;
        // The wait counter restarts on every FETCH so each WAIT begins from zero.
        cnt_d     = state_q == S_FETCH ? 8'd0 : (state_q == S_WAIT ? cnt_q + 8'd1 : cnt_q);
        halt_d    = halt_q | (state_q == S_EXEC && !exec_stall && is_ebreak);
        err_d     = err_q | timed_out;
    end
    always_comb begin
        wr_op = inst_q[6:0] == 7'b0010011 || inst_q[6:0] == 7'b0110011 ||
                inst_q[6:0] == 7'b0110111 || inst_q[6:0] == 7'b0010111 ||
                inst_q[6:0] == 7'b1101111 || inst_q[6:0] == 7'b1100111 ||
                inst_q[6:0] == 7'b0000011;
        // FETCH is the reset state, so the strobe is gated by rst to stay low while held in reset.
        imem_req  = rst && state_q == S_FETCH;
        rf_wen    = retire && wr_op && inst_q[11:7] != 5'd0;
    end
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst      = inst_q;
    assign instret   = instret_q;
    assign halt      = halt_q;
    assign fetch_err = err_q;
endmodule

// File: tb/tb_ysyx_24100005_core_seq.sv
// tb_ysyx_24100005_core_seq: randomized and directed checks against a transaction-level model
module tb_ysyx_24100005_core_seq;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    logic        clk = 1'b0, rst = 1'b0;
    logic        imem_req, imem_rvalid = 1'b0, exec_stall = 1'b0;
    logic        rf_wen, halt, fetch_err;
    logic [31:0] imem_addr, imem_rdata = '0, inst, pc, instret;
    int          n_chk = 0, n_err = 0, wen_cnt = 0;
    logic [31:0] m_pc, m_inst, m_instret;
    logic        m_halt, m_err, m_pend, m_have;
    int          m_waited;
    logic [6:0]  ops [7] = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
                             7'b1101111, 7'b1100111, 7'b0000011};
    ysyx_24100005_core_seq #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .exec_stall(exec_stall),
        .inst(inst), .pc(pc), .rf_wen(rf_wen), .instret(instret),
        .halt(halt), .fetch_err(fetch_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic writes(input logic [31:0] i);
        return (i[6:0] inside {7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
                               7'b1101111, 7'b1100111, 7'b0000011}) && i[11:7] != 5'd0;
    endfunction
    function automatic logic [31:0] rand_inst(input int eb_pct);
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = int'($urandom_range(9));
        if (int'($urandom_range(99)) < eb_pct) return EBREAK;
        if (k == 0) return 32'h0000_0073;
        if (k == 1) return r;
        return {r[31:7], ops[$urandom_range(6)]};
    endfunction
    task automatic m_reset();
        m_pc = RESET_PC; m_inst = '0; m_instret = '0;
        m_halt = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_have = 1'b0; m_waited = 0;
    endtask
    task automatic reset_vals(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        chk({tag, "_pc"}, pc, RESET_PC);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_instret"}, instret, 32'd0);
        chk({tag, "_halt"}, {31'b0, halt}, 32'd0);
        chk({tag, "_err"}, {31'b0, fetch_err}, 32'd0);
        chk({tag, "_wen"}, {31'b0, rf_wen}, 32'd0);
    endtask
    task automatic do_reset();
        rst = 1'b0; imem_rvalid = 1'b0; exec_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_vals("rst");
        rst = 1'b1;
        m_reset();
        wen_cnt = 0;
    endtask
    // One clock cycle: drive inputs at the falling edge, compare against the model, advance the model.
    task automatic step(input logic rv, input logic [31:0] rd, input logic st);
        logic ereq, ewen;
        imem_rvalid = rv; imem_rdata = rd; exec_stall = st;
        #1;
        ereq = !m_halt && !m_err && !m_pend && !m_have;
        ewen = !m_halt && !m_err && m_have && !st && m_inst != EBREAK && writes(m_inst);
        chk("imem_req", {31'b0, imem_req}, {31'b0, ereq});
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("inst", inst, m_inst);
        chk("instret", instret, m_instret);
        chk("halt", {31'b0, halt}, {31'b0, m_halt});
        chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
        chk("rf_wen", {31'b0, rf_wen}, {31'b0, ewen});
        if (rf_wen) wen_cnt++;
        if (m_halt || m_err) begin
        end else if (ereq) begin
            m_pend = 1'b1; m_waited = 0;
        end else if (m_pend) begin
            if (rv) begin
                m_inst = rd; m_have = 1'b1; m_pend = 1'b0;
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin m_err = 1'b1; m_pend = 1'b0; end
            end
        end else if (m_have && !st) begin
            if (m_inst == EBREAK) m_halt = 1'b1;
            else begin m_pc = m_pc + 32'd4; m_instret = m_instret + 32'd1; end
            m_have = 1'b0;
        end
        @(negedge clk);
    endtask
    task automatic episode(input int n, input int rv_pct, input int st_pct, input int eb_pct);
        do_reset();
        for (int i = 0; i < n; i++)
            step(int'($urandom_range(99)) < rv_pct, rand_inst(eb_pct), int'($urandom_range(99)) < st_pct);
    endtask
    initial begin
        // addi x1,x0,5 with a one-cycle memory
        do_reset();
        step(1'b0, '0, 1'b0);
        step(1'b1, 32'h0050_0093, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("d33_wen_pulses", 32'(wen_cnt), 32'd1);
        chk("d33_pc", pc, 32'h8000_0004);
        chk("d33_instret", instret, 32'd1);
        // four addi x0 never write
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b0); step(1'b1, 32'h0000_0013, 1'b0); step(1'b0, '0, 1'b0);
        end
        chk("d34_wen_pulses", 32'(wen_cnt), 32'd0);
        chk("d34_pc", pc, 32'h8000_0010);
        chk("d34_instret", instret, 32'd4);
        // slow memory then a stalled exec
        do_reset();
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'hDEAD_BEEF, 1'b0);
        step(1'b1, 32'h0050_0093, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h1234_5678, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("d35_inst", inst, 32'h0050_0093);
        chk("d35_wen_pulses", 32'(wen_cnt), 32'd1);
        chk("d35_instret", instret, 32'd1);
        // ebreak at the third instruction
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0);
            step(1'b1, i == 2 ? EBREAK : 32'h0010_0113, 1'b0);
            step(1'b0, '0, 1'b0);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 32'h0050_0093, 1'b0);
        chk("d36_halt", {31'b0, halt}, 32'd1);
        chk("d36_pc", pc, 32'h8000_0008);
        chk("d36_instret", instret, 32'd2);
        // memory never answers
        do_reset();
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, '0, 1'b0);
        chk("d37_err_before", {31'b0, fetch_err}, 32'd0);
        step(1'b0, '0, 1'b0);
        chk("d37_err_after", {31'b0, fetch_err}, 32'd1);
        for (int i = 0; i < 10; i++) step(1'b1, 32'h0050_0093, 1'b0);
        chk("d37_wen_pulses", 32'(wen_cnt), 32'd0);
        // reset mid-WAIT with a response arriving while reset is held
        episode(0, 0, 0, 0);
        for (int i = 0; i < 60; i++) step(1'b1, 32'h0050_0093, 1'b0);
        for (int i = 0; i < 50 && !m_pend; i++) step(1'b0, '0, 1'b0);
        chk("d38_in_wait", {31'b0, m_pend}, 32'd1);
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        #2 rst = 1'b0;
        #1 reset_vals("d38_async");
        @(negedge clk);
        reset_vals("d38_held");
        rst = 1'b1;
        m_reset();
        step(1'b1, 32'h0050_0093, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h0050_0093, 1'b0);
        // randomized episodes with varied memory latency, stalls and halts
        episode(400, 60, 25, 0);
        episode(400, 90, 10, 2);
        episode(400, 30, 50, 1);
        episode(400, 8, 20, 0);
        episode(400, 100, 0, 0);
        episode(400, 50, 30, 3);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
